// File: rtl/uart_pkg.sv
// Shared UART framing definitions: frame states, data width, idle level and
// the parity function used by both the transmit and receive paths.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  // Even parity is the XOR of the data bits; odd parity is its inverse.
  function automatic logic uart_parity(input logic [UART_DATA_BITS-1:0] data,
                                       input logic                      even);
    return even ? (^data) : ~(^data);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period counter: counts 0..divisor-1 while enabled and pulses bit_end on
// the last cycle of each bit. Held at zero while clear is high.
module uart_baud_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] divisor,
  output logic             bit_end
);

  logic [WIDTH-1:0] count;
  logic             last;

  assign last    = (count == divisor - WIDTH'(1));
  assign bit_end = !clear && last;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (last) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmit engine: start bit, 8 data bits LSB first, optional parity
// (compiled in with UART_TX_PARITY_EN) and 1 or 2 stop bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_DIVIDER_WIDTH = 16
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic [CLOCK_DIVIDER_WIDTH-1:0] clock_divider_i,
  input  logic                           write_i,
  input  logic [UART_DATA_BITS-1:0]      data_i,
  input  logic                           two_stop_bits_i,
  input  logic                           parity_bit_i,
  input  logic                           parity_even_i,
  output logic                           serial_o,
  output logic                           write_busy_o
);

  uart_state_t                    state;
  uart_state_t                    state_next;
  logic [2:0]                     bit_idx;
  logic [2:0]                     bit_idx_next;
  logic                           stop_second;
  logic                           stop_second_next;
  logic                           line;
  logic                           line_next;
  logic [UART_DATA_BITS-1:0]      data_q;
  logic [CLOCK_DIVIDER_WIDTH-1:0] div_q;
  logic                           two_stop_q;
  logic                           accept;
  logic                           bit_end;
  logic                           parity_on;

  assign accept       = (state == IDLE) && write_i;
  assign serial_o     = line;
  assign write_busy_o = (state != IDLE);

`ifdef UART_TX_PARITY_EN
  logic par_en_q;
  logic par_even_q;

  assign parity_on = par_en_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      par_en_q   <= 1'b0;
      par_even_q <= 1'b0;
    end else if (accept) begin
      par_en_q   <= parity_bit_i;
      par_even_q <= parity_even_i;
    end
  end
`else
  logic unused_parity;

  assign parity_on     = 1'b0;
  assign unused_parity = parity_bit_i ^ parity_even_i;
`endif

  uart_baud_counter #(
    .WIDTH(CLOCK_DIVIDER_WIDTH)
  ) u_baud (
    .clk     (clock_i),
    .rst     (reset_i),
    .clear   (state == IDLE),
    .divisor (div_q),
    .bit_end (bit_end)
  );

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= IDLE;
      bit_idx     <= '0;
      stop_second <= 1'b0;
      line        <= UART_IDLE_LEVEL;
      data_q      <= '0;
      div_q       <= '0;
      two_stop_q  <= 1'b0;
    end else begin
      state       <= state_next;
      bit_idx     <= bit_idx_next;
      stop_second <= stop_second_next;
      line        <= line_next;
      if (accept) begin
        data_q     <= data_i;
        div_q      <= (clock_divider_i == '0) ? CLOCK_DIVIDER_WIDTH'(1) : clock_divider_i;
        two_stop_q <= two_stop_bits_i;
      end
    end
  end

  always_comb begin
    state_next       = state;
    bit_idx_next     = bit_idx;
    stop_second_next = stop_second;
    case (state)
      IDLE: begin
        bit_idx_next     = '0;
        stop_second_next = 1'b0;
        if (write_i) begin
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            bit_idx_next = '0;
            state_next   = parity_on ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop_second) begin
            stop_second_next = 1'b1;
          end else begin
            stop_second_next = 1'b0;
            state_next       = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Line level is decoded from the next state so serial_o can be a flop
  // while still changing on the same cycle as the state.
  always_comb begin
    line_next = UART_IDLE_LEVEL;
    case (state_next)
      START:   line_next = ~UART_IDLE_LEVEL;
      DATA:    line_next = data_q[bit_idx_next];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_next = uart_parity(data_q, par_even_q);
`endif
      default: line_next = UART_IDLE_LEVEL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: expected line levels are queued per cycle
// when a write is issued and popped against serial_o on the falling edge.
module tb_uart_tx;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic [15:0] clock_divider_i;
  logic        write_i;
  logic [7:0]  data_i;
  logic        two_stop_bits_i;
  logic        parity_bit_i;
  logic        parity_even_i;
  logic        serial_o;
  logic        write_busy_o;

  int tests  = 0;
  int failed = 0;
  logic exp_q[$];

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  uart_tx #(
    .CLOCK_DIVIDER_WIDTH(16)
  ) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .clock_divider_i (clock_divider_i),
    .write_i         (write_i),
    .data_i          (data_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .serial_o        (serial_o),
    .write_busy_o    (write_busy_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic configure(input int div, input bit two, input bit par, input bit even);
    clock_divider_i = 16'(div);
    two_stop_bits_i = two;
    parity_bit_i    = par;
    parity_even_i   = even;
  endtask

  task automatic push_frame(input logic [7:0] d, input int div, input bit two,
                            input bit par, input bit even);
    int   dd;
    logic p;
    dd = (div == 0) ? 1 : div;
    p  = even ? (^d) : ~(^d);
    repeat (dd) exp_q.push_back(1'b0);
    for (int b = 0; b < 8; b++) repeat (dd) exp_q.push_back(d[b]);
    if (par && PAR_BUILD) repeat (dd) exp_q.push_back(p);
    repeat (two ? 2 * dd : dd) exp_q.push_back(1'b1);
  endtask

  // Raise write for one cycle; returns #1 into the first frame cycle.
  task automatic send(input logic [7:0] d);
    @(posedge clock_i) #1;
    write_i = 1'b1;
    data_i  = d;
    @(posedge clock_i) #1;
    write_i = 1'b0;
  endtask

  // Pop and compare the whole queued frame, then check busy has fallen.
  task automatic drain(input string name, input int inject, input int busy_len);
    int   n;
    int   busy_cycles;
    logic e;
    n           = exp_q.size();
    busy_cycles = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clock_i);
      e = exp_q.pop_front();
      if (write_busy_o === 1'b1) busy_cycles++;
      tests++;
      if (serial_o !== e) begin
        failed++;
        $display("FAIL %s line cycle %0d: got %b expected %b", name, i + 1, serial_o, e);
      end
      if (i == inject) begin
        write_i         = 1'b1;
        data_i          = 8'h34;
        clock_divider_i = 16'd1;
      end else if (i == inject + 1) begin
        write_i = 1'b0;
      end
    end
    @(negedge clock_i);
    tests++;
    if (write_busy_o !== 1'b0) begin
      failed++;
      $display("FAIL %s busy_fall: got %b expected 0", name, write_busy_o);
    end
    tests++;
    if (serial_o !== 1'b1) begin
      failed++;
      $display("FAIL %s idle_line: got %b expected 1", name, serial_o);
    end
    tests++;
    if (busy_cycles != busy_len) begin
      failed++;
      $display("FAIL %s busy_len: got %0d expected %0d", name, busy_cycles, busy_len);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    write_i = 1'b0;
    data_i  = 8'h00;
    configure(4, 0, 0, 0);
    repeat (3) @(posedge clock_i);
    @(negedge clock_i);
    tests++;
    if (serial_o !== 1'b1) begin
      failed++;
      $display("FAIL reset_line: got %b expected 1", serial_o);
    end
    tests++;
    if (write_busy_o !== 1'b0) begin
      failed++;
      $display("FAIL reset_busy: got %b expected 0", write_busy_o);
    end
    @(posedge clock_i) #1;
    reset_i = 1'b0;
    repeat (2) @(negedge clock_i);
    tests++;
    if (serial_o !== 1'b1 || write_busy_o !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_reset: got line %b busy %b expected 1 0", serial_o, write_busy_o);
    end
  endtask

  task automatic test_8n1();
    configure(4, 0, 0, 0);
    push_frame(8'h55, 4, 0, 0, 0);
    send(8'h55);
    drain("8n1_55", -1, 40);
  endtask

  task automatic test_parity();
    configure(3, 0, 1, 1);
    push_frame(8'h07, 3, 0, 1, 1);
    send(8'h07);
    drain("even_07", -1, PAR_BUILD ? 33 : 30);
    configure(3, 0, 1, 0);
    push_frame(8'h07, 3, 0, 1, 0);
    send(8'h07);
    drain("odd_07", -1, PAR_BUILD ? 33 : 30);
    configure(2, 0, 1, 1);
    push_frame(8'hB4, 2, 0, 1, 1);
    send(8'hB4);
    drain("even_b4", -1, PAR_BUILD ? 22 : 20);
  endtask

  task automatic test_two_stop();
    configure(2, 1, 0, 0);
    push_frame(8'hA0, 2, 1, 0, 0);
    send(8'hA0);
    drain("2stop_a0", -1, 22);
  endtask

  task automatic test_div_zero();
    configure(0, 0, 0, 0);
    push_frame(8'hFF, 0, 0, 0, 0);
    send(8'hFF);
    drain("div0_ff", -1, 10);
  endtask

  task automatic test_ignored_write();
    configure(4, 0, 0, 0);
    push_frame(8'h12, 4, 0, 0, 0);
    send(8'h12);
    drain("busy_write", 5, 40);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock_i);
      tests++;
      if (serial_o !== 1'b1 || write_busy_o !== 1'b0) begin
        failed++;
        $display("FAIL not_queued cycle %0d: got line %b busy %b expected 1 0", i, serial_o, write_busy_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    configure(2, 0, 0, 0);
    push_frame(8'h12, 2, 0, 0, 0);
    send(8'h12);
    drain("b2b_first", -1, 20);
    write_i = 1'b1;
    data_i  = 8'h34;
    push_frame(8'h34, 2, 0, 0, 0);
    @(posedge clock_i) #1;
    write_i = 1'b0;
    drain("b2b_second", -1, 20);
  endtask

  task automatic test_reset_midframe();
    logic e;
    configure(4, 0, 0, 0);
    push_frame(8'h55, 4, 0, 0, 0);
    send(8'h55);
    for (int i = 0; i < 14; i++) begin
      @(negedge clock_i);
      e = exp_q.pop_front();
      tests++;
      if (serial_o !== e) begin
        failed++;
        $display("FAIL pre_reset line cycle %0d: got %b expected %b", i + 1, serial_o, e);
      end
    end
    @(posedge clock_i) #1;
    reset_i = 1'b1;
    exp_q.delete();
    @(posedge clock_i) #1;
    reset_i = 1'b0;
    tests++;
    if (serial_o !== 1'b1 || write_busy_o !== 1'b0) begin
      failed++;
      $display("FAIL mid_reset: got line %b busy %b expected 1 0", serial_o, write_busy_o);
    end
    write_i = 1'b1;
    data_i  = 8'hC3;
    push_frame(8'hC3, 4, 0, 0, 0);
    @(posedge clock_i) #1;
    write_i = 1'b0;
    drain("after_reset_c3", -1, 40);
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_parity();
    test_two_stop();
    test_div_zero();
    test_ignored_write();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Standalone UART transmit engine: accepts one byte over a write/busy handshake and serializes it onto `serial_o` as a configurable asynchronous frame. The frame is one start bit, 8 data bits LSB first, an optional parity bit and 1 or 2 stop bits. It is the drive side of the framing used by the UART receive path and has the same host-facing handshake as the UART core's write port, so a loopback or command responder can drive it directly.

## Interface
- `CLOCK_DIVIDER_WIDTH`, 16, width of the bit-period divider input.
- `clock_i` in 1: system clock; all logic is on the rising edge.
- `reset_i` in 1: synchronous, active-high reset.
- `clock_divider_i` in `CLOCK_DIVIDER_WIDTH`: clock cycles per serial bit; the value 0 is treated as 1.
- `write_i` in 1: request to transmit `data_i`; accepted only when `write_busy_o` is 0.
- `data_i` in 8: byte to send; sampled on the accepting cycle.
- `two_stop_bits_i` in 1: 1 selects two stop bits, 0 selects one.
- `parity_bit_i` in 1: 1 inserts a parity bit after the data bits.
- `parity_even_i` in 1: 1 selects even parity, 0 selects odd.
- `serial_o` out 1: serial line; idle level is high.
- `write_busy_o` out 1: high while a frame is in progress.

## Operation
- Reset values: `serial_o`=1, `write_busy_o`=0, state IDLE, all counters 0. Reset mid-frame aborts the frame immediately; the line returns high on the next cycle.
- States: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE: drives `serial_o`=1. If `write_i`=1, the block latches `data_i`, the divider value (0→1), `two_stop_bits_i`, `parity_bit_i` and `parity_even_i`, then enters START. Changes to these inputs during a frame have no effect.
- START: drives 0 for D cycles, where D is the latched divider.
- DATA: drives data[0] through data[7], D cycles each; a 3-bit index counts 0..7.
- PARITY (only if the latched parity_bit is 1): drives the XOR of the 8 data bits for even parity, or its inverse for odd parity, for D cycles.
- STOP: drives 1 for D cycles, or 2·D cycles when two stop bits are latched, then enters IDLE.
- Bit counter: counts 0..D−1 and wraps to 0 at the end of each bit; it is `CLOCK_DIVIDER_WIDTH` wide with no overflow.
- `write_i` while busy is ignored and is not queued.

## Timing
- A write accepted at cycle n gives `serial_o`=0 and `write_busy_o`=1 from cycle n+1.
- Frame length is N·D cycles, where N = 10 + parity + extra stop bit, so N ranges from 10 to 12.
- `write_busy_o` is high for exactly N·D cycles, from n+1 through n+N·D, and falls at cycle n+N·D+1.
- Back-to-back writes: a write presented on the cycle busy falls is accepted. The next start bit begins one cycle later, giving a minimum inter-frame idle of 1 cycle.
- `serial_o` is a registered output and has no combinational path from the inputs.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state and parity logic are compiled in, and `parity_bit_i`/`parity_even_i` behave as described above.
- Not defined: the parity logic is removed, both parity ports are ignored, and N = 10 or 11.

## Structure
- Shared package `uart_pkg` holds:
  - the frame state enum (IDLE, START, DATA, PARITY, STOP);
  - `UART_DATA_BITS` = 8;
  - the idle-level constant (1);
  - the shared parity function, also used by the receive path.
- Sub-module `uart_baud_counter` takes a latched divider plus a start/clear input and produces a one-cycle end-of-bit pulse. The same counter is reusable on the RX side.

## Test plan
- Divider 4, 8N1, write 0x55 at cycle 0 → cycles 1–40: line 0, then 1,0,1,0,1,0,1,0 at 4 cycles each, then a stop bit of 1; busy falls at cycle 41.
- Divider 3, even parity, 1 stop bit, data 0x07 → parity bit 1 on cycles 28–30; a second run with odd parity gives parity bit 0; busy lasts 33 cycles.
- Divider 2, two stop bits, no parity, data 0xA0 → stop bits high for 4 cycles; busy lasts 22 cycles.
- Divider 0, data 0xFF → treated as D=1, so the frame is 10 cycles: one low start cycle, then line high.
- Write 0x12 followed by a second write (0x34) while busy → only 0x12 is sent. Writing 0x34 on the cycle busy falls sends it starting one cycle later.
- Assert `reset_i` on cycle 15 of a divider-4 frame → `serial_o`=1 and `write_busy_o`=0 on cycle 16, and a new write is accepted on cycle 16.
